// File: rtl/shift_register_univ_pkg.sv
// Shared definitions for the universal shift register:
// operation encodings and the per-cell data-select type.
package shift_register_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;

  // Cell input select: keep, take lower
  // neighbour (bit i-1), upper neighbour
  // (bit i+1) or the parallel data bit.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2,
    SEL_LOAD = 2'd3
  } sel_e;

endpackage

// File: rtl/shift_register_univ_if.sv
// Control/data bundle of the universal shift register.
// master drives en/mode/sin_r/sin_l/pdata; slave returns q, serial outs, count, word_done.
interface shift_register_univ_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic [CW-1:0]    shift_cnt;
  logic             word_done;

  modport master (
    output en, mode, sin_r, sin_l, pdata,
    input  q, sout_msb, sout_lsb,
    input  shift_cnt, word_done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pdata,
    output q, sout_msb, sout_lsb,
    output shift_cnt, word_done
  );

endinterface

// File: rtl/shift_register_univ_cell.sv
// One storage bit: 4:1 mux (hold/lower/upper/load) into a flop.
// Ports: i_clk, i_rst_n (sync, active-low), i_sel, i_lo, i_hi, i_ld, o_q.
module shift_cell
  import shift_register_pkg::*;
#(
  parameter logic INIT_BIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  sel_e i_sel,
  input  logic i_lo,
  input  logic i_hi,
  input  logic i_ld,
  output logic o_q
);

  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    unique case (i_sel)
      SEL_LO:   w_d = i_lo;
      SEL_HI:   w_d = i_hi;
      SEL_LOAD: w_d = i_ld;
      default:  w_d = r_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= INIT_BIT;
    else          r_q <= w_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register: hold, shift, rotate, load, word counter.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of shift_register_univ_if).
module shift_register_univ
  import shift_register_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_register_univ_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  sel_e             w_sel;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_shift;
  logic             w_lo_edge;
  logic             w_hi_edge;
  logic [CW-1:0]    r_cnt;
  logic             r_wd;

  always_comb begin
    w_sel   = SEL_HOLD;
    w_shift = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_SHL, MODE_ROTL: begin
          w_sel   = SEL_LO;
          w_shift = 1'b1;
        end
        MODE_SHR, MODE_ROTR: begin
          w_sel   = SEL_HI;
          w_shift = 1'b1;
        end
        MODE_LOAD: w_sel = SEL_LOAD;
        default:   w_sel = SEL_HOLD;
      endcase
    end
  end

  // Edge cells take the serial input, or the
  // opposite end of q when rotating.
  assign w_lo_edge = (bus.mode == MODE_ROTL)
                   ? w_q[WIDTH-1] : bus.sin_r;
  assign w_hi_edge = (bus.mode == MODE_ROTR)
                   ? w_q[0] : bus.sin_l;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_lo_edge
      assign w_lo[i] = w_lo_edge;
    end else begin : g_lo_mid
      assign w_lo[i] = w_q[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi_edge
      assign w_hi[i] = w_hi_edge;
    end else begin : g_hi_mid
      assign w_hi[i] = w_q[i+1];
    end

    shift_cell #(
      .INIT_BIT (INIT[i])
    ) u_cell (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_sel   (w_sel),
      .i_lo    (w_lo[i]),
      .i_hi    (w_hi[i]),
      .i_ld    (bus.pdata[i]),
      .o_q     (w_q[i])
    );
  end

  // Counts operations, not position; the
  // WIDTH-th shift wraps and pulses word_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_wd  <= 1'b0;
    end else begin
      r_wd <= 1'b0;
      if (bus.en && bus.mode == MODE_LOAD) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_cnt <= '0;
          r_wd  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.q         = w_q;
  assign bus.sout_msb  = w_q[WIDTH-1];
  assign bus.sout_lsb  = w_q[0];
  assign bus.shift_cnt = r_cnt;
  assign bus.word_done = r_wd;

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench: WIDTH=4 and WIDTH=8 instances driven in lockstep.
// Arithmetic reference model pushes expectations; a monitor pops and compares.
module tb_shift_register_univ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_register_univ_if #(.WIDTH(4)) bus4 ();
  shift_register_univ_if #(.WIDTH(8)) bus8 ();

  shift_register_univ #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  shift_register_univ #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  typedef struct {
    int q4; int c4; int w4;
    int q8; int c8; int w8;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int m4q = 0, m4c = 0, m8q = 0, m8c = 0;
  int pq4 = 0, pq8 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Next state from the operation's arithmetic meaning.
  function automatic void mstep(
    input  int       w,
    input  int       q,
    input  int       c,
    input  bit       r,
    input  bit       e,
    input  bit [2:0] md,
    input  bit       sr,
    input  bit       sl,
    input  int       pd,
    output int       nq,
    output int       nc,
    output int       nwd
  );
    int full;
    int half;
    full = 1 << w;
    half = full / 2;
    nq = q;
    nc = c;
    nwd = 0;
    if (!r) begin
      nq = 0;
      nc = 0;
    end else if (e) begin
      case (md)
        3'd1: nq = (q * 2 + int'(sr)) % full;
        3'd2: nq = q / 2 + int'(sl) * half;
        3'd3: begin nq = pd % full; nc = 0; end
        3'd4: nq = (q * 2) % full + q / half;
        3'd5: nq = q / 2 + (q % 2) * half;
        default: ;
      endcase
      if (md == 3'd1 || md == 3'd2 || md == 3'd4 || md == 3'd5) begin
        nc = c + 1;
        if (nc == w) begin
          nc = 0;
          nwd = 1;
        end
      end
    end
  endfunction

  task automatic drive(
    input bit       r,
    input bit       e,
    input bit [2:0] md,
    input bit       sr,
    input bit       sl,
    input int       pd
  );
    exp_t x;
    @(negedge clk);
    rst_n      = r;
    bus4.en    = e;
    bus8.en    = e;
    bus4.mode  = md;
    bus8.mode  = md;
    bus4.sin_r = sr;
    bus8.sin_r = sr;
    bus4.sin_l = sl;
    bus8.sin_l = sl;
    bus4.pdata = pd[3:0];
    bus8.pdata = pd[7:0];
    pq4 = m4q;
    pq8 = m8q;
    mstep(4, m4q, m4c, r, e, md, sr, sl, pd, x.q4, x.c4, x.w4);
    mstep(8, m8q, m8c, r, e, md, sr, sl, pd, x.q8, x.c8, x.w8);
    m4q = x.q4; m4c = x.c4;
    m8q = x.q8; m8c = x.c8;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("q4", int'(bus4.q), x.q4);
      chk("cnt4", int'(bus4.shift_cnt), x.c4);
      chk("wd4", int'(bus4.word_done), x.w4);
      chk("msb4", int'(bus4.sout_msb), (x.q4 >> 3) & 1);
      chk("lsb4", int'(bus4.sout_lsb), x.q4 & 1);
      chk("q8", int'(bus8.q), x.q8);
      chk("cnt8", int'(bus8.shift_cnt), x.c8);
      chk("wd8", int'(bus8.word_done), x.w8);
      chk("msb8", int'(bus8.sout_msb), (x.q8 >> 7) & 1);
      chk("lsb8", int'(bus8.sout_lsb), x.q8 & 1);
    end
  end

  initial begin
    bus4.en = 0; bus8.en = 0;
    bus4.mode = 0; bus8.mode = 0;
    bus4.sin_r = 0; bus8.sin_r = 0;
    bus4.sin_l = 0; bus8.sin_l = 0;
    bus4.pdata = 0; bus8.pdata = 0;

    drive(0, 1, 3'd1, 1, 1, 0);
    drive(0, 0, 3'd0, 0, 0, 0);
    // SHL 1,0,1,1
    drive(1, 1, 3'd1, 1, 0, 0);
    drive(1, 1, 3'd1, 0, 0, 0);
    drive(1, 1, 3'd1, 1, 0, 0);
    drive(1, 1, 3'd1, 1, 0, 0);
    // LOAD 1001, SHR with sin_l=0
    drive(1, 1, 3'd3, 0, 0, 'h99);
    drive(1, 1, 3'd2, 0, 0, 0);
    // LOAD 1001, ROTL x4, ROTR x1
    drive(1, 1, 3'd3, 0, 0, 'h99);
    repeat (4) drive(1, 1, 3'd4, 0, 0, 0);
    drive(1, 1, 3'd5, 0, 0, 0);
    // en=0 with SHL, then reserved mode
    repeat (3) drive(1, 0, 3'd1, 1, 1, 'hff);
    drive(1, 1, 3'd6, 1, 1, 'hff);
    drive(1, 1, 3'd7, 1, 1, 'hff);
    // LOAD mid-word
    repeat (2) drive(1, 1, 3'd1, 1, 0, 0);
    drive(1, 1, 3'd3, 0, 0, 'h66);
    // reset mid-word, dropped mid-cycle
    repeat (2) drive(1, 1, 3'd1, 1, 0, 0);
    drive(0, 1, 3'd1, 1, 0, 0);
    #2;
    chk("midrst_q4", int'(bus4.q), pq4);
    chk("midrst_q8", int'(bus8.q), pq8);
    // full WIDTH=8 word
    for (int i = 0; i < 8; i++) drive(1, 1, 3'd1, i[0], 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit r;
      bit e;
      r = ($urandom_range(0, 39) != 0);
      e = ($urandom_range(0, 7) != 0);
      drive(r, e, 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom),
            int'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
